reg_dump_streamer: RTL and testbench

- Read-side companion to the Processor's register outputs w0..w15.
- On a start request it atomically snapshots all 16 architectural registers.
- It then streams them one word per accepted beat over a valid/ready interface, followed by a 16-bit additive checksum word.
- Used by benches and debug logic to read out processor state without stalling the core.

---
 rtl/dump_pkg.sv | 20 ++
 rtl/reg_snapshot_bank.sv | 40 ++++
 rtl/reg_dump_streamer.sv | 128 ++++++++++++
 tb/tb_reg_dump_streamer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dump_pkg
//  Purpose  : Shared sizes and FSM encoding for the register dump streamer.
//  Revision : 1.0
// ============================================================================
package dump_pkg;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2
    } dump_state_t;

endpackage : dump_pkg
`default_nettype wire

// File: rtl/reg_snapshot_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reg_snapshot_bank
//  Purpose  : 16x16 snapshot array, loaded in one cycle, read by index.
//  Revision : 1.0
// ============================================================================
module reg_snapshot_bank
    import dump_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_capture,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  i_words,
    input  logic [IDX_W-1:0]                 i_rd_idx,
    output logic [DATA_W-1:0]                o_rd_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] snap_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] snap_d;

    // All words load together so the dump reflects one instant of the core.
    always_comb begin
        snap_d = snap_q;
        if (i_capture) begin
            snap_d = i_words;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign o_rd_data = snap_q[i_rd_idx];

endmodule : reg_snapshot_bank
`default_nettype wire

// File: rtl/reg_dump_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_streamer
//  Purpose  : Snapshots w0..w15 on start and streams them plus a checksum.
//  Revision : 1.0
// ============================================================================
module reg_dump_streamer
    import dump_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] w0,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] w3,
    input  logic [DATA_W-1:0] w4,
    input  logic [DATA_W-1:0] w5,
    input  logic [DATA_W-1:0] w6,
    input  logic [DATA_W-1:0] w7,
    input  logic [DATA_W-1:0] w8,
    input  logic [DATA_W-1:0] w9,
    input  logic [DATA_W-1:0] w10,
    input  logic [DATA_W-1:0] w11,
    input  logic [DATA_W-1:0] w12,
    input  logic [DATA_W-1:0] w13,
    input  logic [DATA_W-1:0] w14,
    input  logic [DATA_W-1:0] w15,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    dump_state_t                     state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [DATA_W-1:0]               sum_q, sum_d;
    logic                            done_q, done_d;
    logic                            capture;
    logic [DATA_W-1:0]               snap_word;
    logic [NUM_REGS-1:0][DATA_W-1:0] w_all;

    assign w_all = {w15, w14, w13, w12, w11, w10, w9, w8,
                    w7,  w6,  w5,  w4,  w3,  w2,  w1, w0};

    reg_snapshot_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_capture (capture),
        .i_words   (w_all),
        .i_rd_idx  (idx_q),
        .o_rd_data (snap_word)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        done_d    = 1'b0;
        capture   = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = snap_word;
                out_index = idx_q;
                busy      = 1'b1;
                if (out_ready) begin
                    sum_d = sum_q + snap_word;
                    if (idx_q == LAST_IDX) begin
                        state_d = CHK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            CHK: begin
                out_valid = 1'b1;
                out_data  = sum_q;
                out_last  = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule : reg_dump_streamer
`default_nettype wire

// File: tb/tb_reg_dump_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_streamer
//  Purpose  : Directed self-checking bench for reg_dump_streamer.
//  Revision : 1.0
// ============================================================================
module tb_reg_dump_streamer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] wv [16];
    logic [15:0] exp_w [16];
    logic [15:0] exp_chk;
    int          n_total;
    int          n_bad;

    reg_dump_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .w0        (wv[0]),
        .w1        (wv[1]),
        .w2        (wv[2]),
        .w3        (wv[3]),
        .w4        (wv[4]),
        .w5        (wv[5]),
        .w6        (wv[6]),
        .w7        (wv[7]),
        .w8        (wv[8]),
        .w9        (wv[9]),
        .w10       (wv[10]),
        .w11       (wv[11]),
        .w12       (wv[12]),
        .w13       (wv[13]),
        .w14       (wv[14]),
        .w15       (wv[15]),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start (or leave it high when hold=1) and check first-word latency.
    task automatic kick(input bit hold);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check_val("first_valid", {31'd0, out_valid}, 32'd1);
        check_val("busy_on", {31'd0, busy}, 32'd1);
    endtask

    // mode 0: ready high; mode 1: ready 1,0,0,1; mode 2: ready high + isolation poke
    task automatic drain(input int mode);
        int          beats;
        int          cyc;
        bit          stalled;
        bit          poked;
        logic [15:0] pd;
        logic [3:0]  pi;
        beats = 0; cyc = 0; stalled = 0; poked = 0; pd = '0; pi = '0;
        while (beats < 17 && cyc < 300) begin
            if (mode == 1) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else           out_ready = 1'b1;
            if (stalled) begin
                check_val("stall_data", {16'd0, out_data}, {16'd0, pd});
                check_val("stall_idx", {28'd0, out_index}, {28'd0, pi});
            end
            if (mode == 2) check_val("busy_held", {31'd0, busy}, 32'd1);
            if (out_valid && out_ready) begin
                if (beats < 16) begin
                    check_val("beat_data", {16'd0, out_data}, {16'd0, exp_w[beats]});
                    check_val("beat_idx", {28'd0, out_index}, beats);
                    check_val("beat_last", {31'd0, out_last}, 32'd0);
                end else begin
                    check_val("chk_data", {16'd0, out_data}, {16'd0, exp_chk});
                    check_val("chk_idx", {28'd0, out_index}, 32'd0);
                    check_val("chk_last", {31'd0, out_last}, 32'd1);
                end
                beats++;
                stalled = 0;
            end else if (out_valid) begin
                stalled = 1;
                pd = out_data;
                pi = out_index;
            end
            if (mode == 2) begin
                if (beats == 1 && !poked) begin
                    for (int k = 0; k < 16; k++) wv[k] = 16'hAAAA;
                    start = 1'b1;
                    poked = 1;
                end else begin
                    start = 1'b0;
                end
            end
            cyc++;
            @(negedge clk);
        end
        check_val("beat_count", beats, 32'd17);
        if (mode != 1) check_val("no_bubble_cycles", cyc, 32'd17);
        check_val("done_pulse", {31'd0, done}, 32'd1);
        check_val("busy_in_done", {31'd0, busy}, 32'd0);
        check_val("valid_in_done", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic load_inc();
        for (int k = 0; k < 16; k++) begin
            wv[k]    = 16'(k + 1);
            exp_w[k] = 16'(k + 1);
        end
        exp_chk = 16'h0088;
    endtask

    initial begin
        bit found;
        n_total = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin wv[k] = '0; exp_w[k] = '0; end
        exp_chk = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_data", {16'd0, out_data}, 32'd0);
        check_val("rst_index", {28'd0, out_index}, 32'd0);
        check_val("rst_last", {31'd0, out_last}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic dump
        load_inc();
        kick(0);
        drain(0);
        @(negedge clk);
        check_val("done_one_cycle", {31'd0, done}, 32'd0);

        // checksum wrap
        for (int k = 0; k < 16; k++) begin wv[k] = 16'hFFFF; exp_w[k] = 16'hFFFF; end
        exp_chk = 16'hFFF0;
        kick(0);
        drain(0);
        @(negedge clk);

        // backpressure
        for (int k = 0; k < 16; k++) begin wv[k] = 16'(16'h0101 * k); exp_w[k] = 16'(16'h0101 * k); end
        exp_chk = 16'h7878;
        kick(0);
        drain(1);
        @(negedge clk);

        // snapshot isolation and ignored start
        load_inc();
        kick(0);
        drain(2);
        @(negedge clk);
        check_val("iso_no_redump", {31'd0, out_valid}, 32'd0);
        check_val("iso_idle_busy", {31'd0, busy}, 32'd0);

        // reset mid-stream
        load_inc();
        out_ready = 1'b1;
        kick(0);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (out_valid && out_index == 4'd5) found = 1;
            else @(negedge clk);
        end
        check_val("reach_beat5", {31'd0, found}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_valid", {31'd0, out_valid}, 32'd0);
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_idle", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 16; k++) begin wv[k] = 16'(16'h1000 + k); exp_w[k] = 16'(16'h1000 + k); end
        exp_chk = 16'h0078;
        kick(0);
        drain(0);
        @(negedge clk);

        // back-to-back with start held high
        load_inc();
        kick(1);
        drain(0);
        @(negedge clk);
        check_val("b2b_valid", {31'd0, out_valid}, 32'd1);
        check_val("b2b_index", {28'd0, out_index}, 32'd0);
        check_val("b2b_data", {16'd0, out_data}, 32'd1);
        start = 1'b0;
        drain(0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule : tb_reg_dump_streamer
`default_nettype wire
